ag32gbd_bram_arb: RTL and testbench

//  Single-port arbiter/sequencer for the 1Kx8 camera BRAM. Shares it between four requesters:
//  reg-write (cam regs A006-A035), buffer-write (sensor pipeline), buffer-read (cart RAM writer),
//  reg-read (compare matrix). Maps logical addresses onto the BRAM map and owns A/B ping-pong state.
//  The physical map is 000-0FF buffer A, 100-1FF buffer B, REG_BASE.. registers.

---
 rtl/ag32gbd_bram_arb.sv | 211 +++++++++++++++++++++
 tb/tb_ag32gbd_bram_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_bram_arb.sv
// ag32gbd_bram_arb: single-port arbiter and sequencer for the 1Kx8 camera BRAM.
// Four requesters share the BRAM: reg-write (rw), buffer-write (bw),
// buffer-read (br) and reg-read (rr). The block maps logical addresses onto
// the physical map (000-0FF bank A, 100-1FF bank B, REG_BASE.. registers)
// and owns the front/back ping-pong select.
//
// Handshake: a requester holds *_req high. In the cycle it is granted, the
// BRAM command and that port's *_ack are registered and appear together one
// cycle later. A requester whose *_ack is high is masked from arbitration in
// that cycle, so it must drop *_req at the ack edge for a single access.
// Read data comes back on *_rvalid/*_rdata three cycles after the grant
// cycle when uncontended.
//
// Build option: define AG32GBD_BRAM_ARB_RR_EN for round-robin arbitration
// (search starts at the port after the last winner). When it is undefined,
// fixed priority rw > bw > br > rr is used.
module ag32gbd_bram_arb #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int BUF_OFF_W  = 8,
    parameter int REG_ADDR_W = 6,
    parameter logic [ADDR_W-1:0] REG_BASE = 10'h200
) (
    input  logic                  sys_clock,
    input  logic                  sys_reset,
    input  logic                  flip_req,
    output logic                  front_sel,
    input  logic                  rw_req,
    input  logic [REG_ADDR_W-1:0] rw_addr,
    input  logic [DATA_W-1:0]     rw_data,
    output logic                  rw_ack,
    input  logic                  bw_req,
    input  logic [BUF_OFF_W-1:0]  bw_off,
    input  logic [DATA_W-1:0]     bw_data,
    output logic                  bw_ack,
    input  logic                  br_req,
    input  logic [BUF_OFF_W-1:0]  br_off,
    output logic                  br_ack,
    output logic                  br_rvalid,
    output logic [DATA_W-1:0]     br_rdata,
    input  logic                  rr_req,
    input  logic [REG_ADDR_W-1:0] rr_addr,
    output logic                  rr_ack,
    output logic                  rr_rvalid,
    output logic [DATA_W-1:0]     rr_rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_wdata,
    input  logic [DATA_W-1:0]     bram_rdata
);

    // Port indices in arbitration order.
    localparam logic [1:0] P_RW = 2'd0;
    localparam logic [1:0] P_BW = 2'd1;
    localparam logic [1:0] P_BR = 2'd2;
    localparam logic [1:0] P_RR = 2'd3;

    // Which port an outstanding read belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_BR   = 2'd1,
        TAG_RR   = 2'd2
    } tag_e;

    logic                  front_sel_q, front_sel_d;
    logic [3:0]            ack_q, ack_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    tag_e                  tag1_q, tag1_d;
    tag_e                  tag2_q, tag2_d;
    logic                  br_rvalid_q, br_rvalid_d;
    logic                  rr_rvalid_q, rr_rvalid_d;
    logic [DATA_W-1:0]     br_rdata_q, br_rdata_d;
    logic [DATA_W-1:0]     rr_rdata_q, rr_rdata_d;
`ifdef AG32GBD_BRAM_ARB_RR_EN
    logic [1:0]            ptr_q, ptr_d;
`endif

    logic [3:0] req_v;
    logic [3:0] elig;
    logic [1:0] start;
    logic [1:0] idx;
    logic       gnt_valid;
    logic [1:0] gnt_idx;

    // Arbitration: pick the first eligible port, searching from the start index.
    always_comb begin
        req_v     = {rr_req, br_req, bw_req, rw_req};
        elig      = req_v & ~ack_q;
`ifdef AG32GBD_BRAM_ARB_RR_EN
        start     = ptr_q;
`else
        start     = P_RW;
`endif
        idx       = 2'd0;
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!gnt_valid && elig[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Next-state: BRAM command, acks, read tag pipeline, read capture, bank select.
    always_comb begin
        front_sel_d = front_sel_q ^ flip_req;
        ack_d       = 4'b0000;
        en_d        = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;
`ifdef AG32GBD_BRAM_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        if (gnt_valid) begin
            en_d           = 1'b1;
            ack_d[gnt_idx] = 1'b1;
`ifdef AG32GBD_BRAM_ARB_RR_EN
            ptr_d          = gnt_idx + 2'd1;
`endif
            // Bank bit uses the pre-flip select: the address is fixed at grant.
            case (gnt_idx)
                P_RW: begin
                    we_d    = 1'b1;
                    addr_d  = REG_BASE + ADDR_W'(rw_addr);
                    wdata_d = rw_data;
                end
                P_BW: begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_W'({~front_sel_q, bw_off});
                    wdata_d = bw_data;
                end
                P_BR: begin
                    we_d    = 1'b0;
                    addr_d  = ADDR_W'({front_sel_q, br_off});
                    tag1_d  = TAG_BR;
                end
                default: begin
                    we_d    = 1'b0;
                    addr_d  = REG_BASE + ADDR_W'(rr_addr);
                    tag1_d  = TAG_RR;
                end
            endcase
        end
        // bram_rdata is valid while tag2 is set; capture it into the owner's port.
        br_rvalid_d = (tag2_q == TAG_BR);
        rr_rvalid_d = (tag2_q == TAG_RR);
        br_rdata_d  = br_rvalid_d ? bram_rdata : br_rdata_q;
        rr_rdata_d  = rr_rvalid_d ? bram_rdata : rr_rdata_q;
    end

    // State registers with synchronous reset; reset also drops in-flight reads.
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            front_sel_q <= 1'b0;
            ack_q       <= 4'b0000;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            br_rvalid_q <= 1'b0;
            rr_rvalid_q <= 1'b0;
            br_rdata_q  <= '0;
            rr_rdata_q  <= '0;
`ifdef AG32GBD_BRAM_ARB_RR_EN
            ptr_q       <= P_RW;
`endif
        end else begin
            front_sel_q <= front_sel_d;
            ack_q       <= ack_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            br_rvalid_q <= br_rvalid_d;
            rr_rvalid_q <= rr_rvalid_d;
            br_rdata_q  <= br_rdata_d;
            rr_rdata_q  <= rr_rdata_d;
`ifdef AG32GBD_BRAM_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign front_sel  = front_sel_q;
    assign rw_ack     = ack_q[P_RW];
    assign bw_ack     = ack_q[P_BW];
    assign br_ack     = ack_q[P_BR];
    assign rr_ack     = ack_q[P_RR];
    assign br_rvalid  = br_rvalid_q;
    assign br_rdata   = br_rdata_q;
    assign rr_rvalid  = rr_rvalid_q;
    assign rr_rdata   = rr_rdata_q;
    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

endmodule

// File: tb/tb_ag32gbd_bram_arb.sv
// Testbench for ag32gbd_bram_arb with a behavioural 1Kx8 BRAM and a shadow
// memory holding the contents the BRAM is expected to have.
module tb_ag32gbd_bram_arb;
    logic       sys_clock = 1'b0;
    logic       sys_reset;
    logic       flip_req;
    logic       front_sel;
    logic       rw_req, bw_req, br_req, rr_req;
    logic [5:0] rw_addr, rr_addr;
    logic [7:0] rw_data, bw_data, bw_off, br_off;
    logic       rw_ack, bw_ack, br_ack, rr_ack;
    logic       br_rvalid, rr_rvalid;
    logic [7:0] br_rdata, rr_rdata;
    logic       bram_en, bram_we;
    logic [9:0] bram_addr;
    logic [7:0] bram_wdata, bram_rdata;

    // Behavioural BRAM plus a preload port owned by the bench.
    logic [7:0] mem [0:1023];
    logic       pre_en = 1'b0;
    logic [9:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    logic [7:0]  exp_mem [0:1023];
    logic        exp_front;
    int          m_next;
    logic [3:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;

    logic [3:0]  acks;
    logic [42:0] all_outs;
    assign acks     = {rr_ack, br_ack, bw_ack, rw_ack};
    assign all_outs = {front_sel, acks, br_rvalid, rr_rvalid, br_rdata, rr_rdata,
                       bram_en, bram_we, bram_addr, bram_wdata};

    ag32gbd_bram_arb dut (
        .sys_clock(sys_clock), .sys_reset(sys_reset), .flip_req(flip_req), .front_sel(front_sel),
        .rw_req(rw_req), .rw_addr(rw_addr), .rw_data(rw_data), .rw_ack(rw_ack),
        .bw_req(bw_req), .bw_off(bw_off), .bw_data(bw_data), .bw_ack(bw_ack),
        .br_req(br_req), .br_off(br_off), .br_ack(br_ack), .br_rvalid(br_rvalid), .br_rdata(br_rdata),
        .rr_req(rr_req), .rr_addr(rr_addr), .rr_ack(rr_ack), .rr_rvalid(rr_rvalid), .rr_rdata(rr_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    always #5 sys_clock = ~sys_clock;

    always @(posedge sys_clock) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else bram_rdata <= mem[bram_addr];
        end
    end

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic idle_inputs();
        flip_req = 0; rw_req = 0; bw_req = 0; br_req = 0; rr_req = 0;
        rw_addr = 0; rr_addr = 0; rw_data = 0; bw_data = 0; bw_off = 0; br_off = 0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        checks++; if (all_outs !== 43'd0) begin errors++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
        sys_reset = 1'b0;
        tick();
        checks++; if (all_outs !== 43'd0) begin errors++; $display("FAIL reset_idle: got %h expected 0", all_outs); end
        exp_front = 1'b0;
        m_next = 0;
    endtask

    task automatic test_reg_write();
        rw_req = 1; rw_addr = 6'h06; rw_data = 8'hA5;
        tick();
        rw_req = 0;
        checks++; if (acks !== 4'b0001) begin errors++; $display("FAIL rw_ack: got %b expected 0001", acks); end
        checks++; if ({bram_en, bram_we, bram_addr, bram_wdata} !== {1'b1, 1'b1, 10'h206, 8'hA5}) begin
            errors++; $display("FAIL rw_cmd: got en=%b we=%b addr=%h wdata=%h expected 1 1 206 a5",
                               bram_en, bram_we, bram_addr, bram_wdata); end
        exp_mem[10'h206] = 8'hA5;
        m_next = 1;
        tick();
        checks++; if ({acks, bram_en, bram_addr, bram_wdata} !== {4'b0, 1'b0, 10'h206, 8'hA5}) begin
            errors++; $display("FAIL rw_idle_hold: got ack=%b en=%b addr=%h wdata=%h expected 0000 0 206 a5",
                               acks, bram_en, bram_addr, bram_wdata); end
        tick();
    endtask

    task automatic test_buf_read();
        preload(10'h013, 8'h3C);
        br_req = 1; br_off = 8'h13;
        tick();
        br_req = 0;
        checks++; if ({acks, bram_en, bram_we, bram_addr} !== {4'b0100, 1'b1, 1'b0, 10'h013}) begin
            errors++; $display("FAIL br_cmd: got ack=%b en=%b we=%b addr=%h expected 0100 1 0 013",
                               acks, bram_en, bram_we, bram_addr); end
        tick();
        checks++; if (br_rvalid !== 1'b0) begin errors++; $display("FAIL br_early: got rvalid=%b expected 0", br_rvalid); end
        tick();
        checks++; if ({br_rvalid, br_rdata} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL br_data: got rvalid=%b data=%h expected 1 3c", br_rvalid, br_rdata); end
        tick();
        checks++; if ({br_rvalid, br_rdata} !== {1'b0, 8'h3C}) begin
            errors++; $display("FAIL br_hold: got rvalid=%b data=%h expected 0 3c", br_rvalid, br_rdata); end
        m_next = 3;
    endtask

    task automatic test_flip();
        preload(10'h113, 8'h5A);
        flip_req = 1; bw_req = 1; bw_off = 8'h13; bw_data = 8'h77;
        tick();
        flip_req = 0; bw_req = 0;
        checks++; if ({acks, bram_we, bram_addr, bram_wdata, front_sel} !== {4'b0010, 1'b1, 10'h113, 8'h77, 1'b1}) begin
            errors++; $display("FAIL flip_bw: got ack=%b we=%b addr=%h wdata=%h front=%b expected 0010 1 113 77 1",
                               acks, bram_we, bram_addr, bram_wdata, front_sel); end
        exp_front = 1'b1;
        exp_mem[10'h113] = 8'h77;
        tick(); tick();
        br_req = 1; br_off = 8'h13;
        tick();
        br_req = 0;
        checks++; if (bram_addr !== 10'h113) begin errors++; $display("FAIL flip_br_addr: got %h expected 113", bram_addr); end
        tick(); tick();
        checks++; if ({br_rvalid, br_rdata} !== {1'b1, 8'h77}) begin
            errors++; $display("FAIL flip_br_data: got rvalid=%b data=%h expected 1 77", br_rvalid, br_rdata); end
        m_next = 3;
        // Two consecutive flip pulses toggle twice.
        flip_req = 1;
        tick();
        checks++; if (front_sel !== ~exp_front) begin errors++; $display("FAIL flip_one: got %b expected %b", front_sel, ~exp_front); end
        tick();
        flip_req = 0;
        checks++; if (front_sel !== exp_front) begin errors++; $display("FAIL flip_two: got %b expected %b", front_sel, exp_front); end
        tick();
    endtask

    task automatic test_priority();
        int w;
        int p;
        int cnt [4];
        logic [3:0] e;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        rw_addr = 6'($urandom_range(0, 63)); rw_data = 8'($urandom);
        bw_off = 8'($urandom); bw_data = 8'($urandom);
        br_off = 8'($urandom); rr_addr = 6'($urandom_range(0, 63));
        rw_req = 1; bw_req = 1; br_req = 1; rr_req = 1;
        w = -1;
        for (int c = 0; c < 8; c++) begin
            // Winner: first port in search order that was not acked last cycle.
            p = w;
            w = -1;
            for (int k = 0; k < 4; k++) begin
`ifdef AG32GBD_BRAM_ARB_RR_EN
                if (w < 0 && ((m_next + k) % 4) != p) w = (m_next + k) % 4;
`else
                if (w < 0 && k != p) w = k;
`endif
            end
            exp_q.push_back(4'(1 << w));
            m_next = (w + 1) % 4;
            if (w == 0) exp_mem[10'h200 + 10'(rw_addr)] = rw_data;
            if (w == 1) exp_mem[{1'b0, ~exp_front, bw_off}] = bw_data;
            tick();
            if (c == 7) begin rw_req = 0; bw_req = 0; br_req = 0; rr_req = 0; end
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) if (acks[i]) cnt[i]++;
            checks++; if (acks !== e) begin errors++; $display("FAIL prio_c%0d: got ack=%b expected %b", c, acks, e); end
        end
`ifdef AG32GBD_BRAM_ARB_RR_EN
        checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2) begin
            errors++; $display("FAIL rr_share: got %0d %0d %0d %0d expected 2 each", cnt[0], cnt[1], cnt[2], cnt[3]); end
`else
        checks++; if (cnt[0] != 4 || cnt[2] != 0 || cnt[3] != 0) begin
            errors++; $display("FAIL fixed_share: got rw=%0d br=%0d rr=%0d expected 4 0 0", cnt[0], cnt[2], cnt[3]); end
`endif
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ob;
        logic [5:0] ra;
        logic [7:0] eb, er;
        ob = 8'($urandom); ra = 6'($urandom_range(0, 63));
        eb = exp_mem[{1'b0, exp_front, ob}];
        er = exp_mem[10'h200 + 10'(ra)];
        br_req = 1; br_off = ob;
        tick();
        br_req = 0; rr_req = 1; rr_addr = ra;
        checks++; if (acks !== 4'b0100) begin errors++; $display("FAIL b2b_br_ack: got %b expected 0100", acks); end
        tick();
        rr_req = 0;
        checks++; if (acks !== 4'b1000) begin errors++; $display("FAIL b2b_rr_ack: got %b expected 1000", acks); end
        tick();
        checks++; if ({br_rvalid, rr_rvalid, br_rdata} !== {1'b1, 1'b0, eb}) begin
            errors++; $display("FAIL b2b_br_ret: got brv=%b rrv=%b data=%h expected 1 0 %h", br_rvalid, rr_rvalid, br_rdata, eb); end
        tick();
        checks++; if ({br_rvalid, rr_rvalid, rr_rdata, br_rdata} !== {1'b0, 1'b1, er, eb}) begin
            errors++; $display("FAIL b2b_rr_ret: got brv=%b rrv=%b rr=%h br=%h expected 0 1 %h %h",
                               br_rvalid, rr_rvalid, rr_rdata, br_rdata, er, eb); end
        m_next = 0;
        tick();
    endtask

    task automatic test_random();
        int kind;
        logic fl;
        logic [9:0] ea;
        logic [7:0] d, off;
        logic [5:0] a6;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            fl = ($urandom_range(0, 3) == 0);
            a6 = 6'($urandom_range(0, 63)); off = 8'($urandom); d = 8'($urandom);
            case (kind)
                0: begin rw_req = 1; rw_addr = a6; rw_data = d; ea = 10'h200 + 10'(a6); end
                1: begin bw_req = 1; bw_off = off; bw_data = d; ea = {1'b0, ~exp_front, off}; end
                2: begin br_req = 1; br_off = off; ea = {1'b0, exp_front, off}; end
                default: begin rr_req = 1; rr_addr = a6; ea = 10'h200 + 10'(a6); end
            endcase
            flip_req = fl;
            tick();
            idle_inputs();
            if (fl) exp_front = ~exp_front;
            m_next = (kind + 1) % 4;
            checks++; if ({acks, bram_en, bram_we, bram_addr, front_sel} !== {4'(1 << kind), 1'b1, (kind < 2), ea, exp_front}) begin
                errors++; $display("FAIL rnd%0d_cmd: got ack=%b en=%b we=%b addr=%h front=%b expected %b 1 %b %h %b",
                                   n, acks, bram_en, bram_we, bram_addr, front_sel, 4'(1 << kind), (kind < 2), ea, exp_front); end
            if (kind < 2) begin
                checks++; if (bram_wdata !== d) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, bram_wdata, d); end
                exp_mem[ea] = d;
            end
            tick();
            checks++; if ({br_rvalid, rr_rvalid} !== 2'b00) begin errors++; $display("FAIL rnd%0d_early: got %b%b expected 00", n, br_rvalid, rr_rvalid); end
            tick();
            checks++; if ({br_rvalid, rr_rvalid} !== {kind == 2, kind == 3}) begin
                errors++; $display("FAIL rnd%0d_rvalid: got %b%b expected %b%b", n, br_rvalid, rr_rvalid, kind == 2, kind == 3); end
            if (kind == 2) begin
                checks++; if (br_rdata !== exp_mem[ea]) begin errors++; $display("FAIL rnd%0d_br: got %h expected %h", n, br_rdata, exp_mem[ea]); end
            end
            if (kind == 3) begin
                checks++; if (rr_rdata !== exp_mem[ea]) begin errors++; $display("FAIL rnd%0d_rr: got %h expected %h", n, rr_rdata, exp_mem[ea]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        exp_front = 1'b1;
        flip_req = (front_sel == 1'b0);
        tick();
        flip_req = 0;
        br_req = 1; br_off = 8'($urandom);
        tick();
        br_req = 0;
        tick();
        sys_reset = 1;
        tick();
        checks++; if (all_outs !== 43'd0) begin errors++; $display("FAIL rst_mid_outs: got %h expected 0", all_outs); end
        sys_reset = 0;
        tick();
        checks++; if ({br_rvalid, front_sel, all_outs} !== 45'd0) begin
            errors++; $display("FAIL rst_mid_after: got rvalid=%b front=%b outs=%h expected 0 0 0", br_rvalid, front_sel, all_outs); end
        exp_front = 1'b0;
        m_next = 0;
    endtask

    initial begin
        sys_reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) preload(10'(i), 8'($urandom));
        test_reset();
        test_reg_write();
        test_buf_read();
        test_flip();
        test_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
